// File: rtl/pwm_gen.sv
// pwm_gen: fixed-period PWM with the duty value shadow-latched once per period
module pwm_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dty,
  output logic             pwm,
  output logic             period_start
);
  logic [WIDTH-1:0] cnt_q, cnt_d, dty_q, dty_d;
  logic             pwm_q, pwm_d, period_start_q, period_start_d;
  always_comb begin
    cnt_d          = cnt_q + 1'b1;
    dty_d          = (&cnt_q) ? dty : dty_q;
    pwm_d          = cnt_q < dty_q;
    period_start_d = cnt_q == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      dty_q          <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      dty_q          <= dty_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end
  assign pwm          = pwm_q;
  assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: scoreboard bench for pwm_gen at WIDTH=8 and WIDTH=4
module tb_pwm_gen;
  logic       clk = 1'b0;
  logic       rst_n, rst_n4;
  logic [7:0] dty;
  logic [3:0] dty4;
  logic       pwm, period_start, pwm4, period_start4;
  int         checks = 0;
  int         failures = 0;
  typedef struct {
    logic  p;
    logic  s;
    string tag;
  } exp_t;
  exp_t q8[$];
  exp_t q4[$];
  always #5 clk = ~clk;
  pwm_gen #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .dty(dty), .pwm(pwm), .period_start(period_start));
  pwm_gen #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n4), .dty(dty4), .pwm(pwm4), .period_start(period_start4));
  // Each entry describes the outputs expected just after the next rising edge.
  task automatic step(input bit w4, input logic rn, input logic [7:0] d, input logic ep, input logic es,
                      input string tag);
    exp_t e;
    @(negedge clk);
    e.p = ep;
    e.s = es;
    e.tag = tag;
    if (w4) begin
      rst_n4 = rn;
      dty4 = d[3:0];
      q4.push_back(e);
    end else begin
      rst_n = rn;
      dty = d;
      q8.push_back(e);
    end
  endtask
  task automatic period(input bit w4, input int len, input int hi, input logic [7:0] d, input int chg,
                        input logic [7:0] d2, input string tag);
    for (int i = 0; i < len; i++) step(w4, 1'b1, (i >= chg) ? d2 : d, i < hi, i == 0, tag);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() != 0) begin
        e = q8.pop_front();
        checks++;
        if (pwm !== e.p || period_start !== e.s) begin
          failures++;
          $display("FAIL w8 %s t=%0t pwm got %b want %b, period_start got %b want %b",
                   e.tag, $time, pwm, e.p, period_start, e.s);
        end
      end
      if (q4.size() != 0) begin
        e = q4.pop_front();
        checks++;
        if (pwm4 !== e.p || period_start4 !== e.s) begin
          failures++;
          $display("FAIL w4 %s t=%0t pwm got %b want %b, period_start got %b want %b",
                   e.tag, $time, pwm4, e.p, period_start4, e.s);
        end
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    rst_n4 = 1'b0;
    dty = 8'd100;
    dty4 = 4'd0;
    repeat (5) step(1'b0, 1'b0, 8'd100, 1'b0, 1'b0, "reset");
    period(1'b0, 256, 0, 8'd64, 256, 8'd64, "first_low");
    period(1'b0, 256, 64, 8'd64, 256, 8'd64, "steady64");
    period(1'b0, 256, 64, 8'd0, 256, 8'd0, "steady64_last");
    period(1'b0, 256, 0, 8'd0, 256, 8'd0, "dty0_a");
    period(1'b0, 256, 0, 8'd0, 256, 8'd0, "dty0_b");
    period(1'b0, 256, 0, 8'd255, 256, 8'd255, "dty0_c");
    period(1'b0, 256, 255, 8'd255, 256, 8'd255, "dty255_a");
    period(1'b0, 256, 255, 8'd200, 256, 8'd200, "dty255_b");
    period(1'b0, 256, 200, 8'd200, 50, 8'd10, "mid_update");
    period(1'b0, 256, 10, 8'd128, 256, 8'd128, "after_update");
    period(1'b0, 30, 128, 8'd128, 256, 8'd128, "pre_reset");
    step(1'b0, 1'b0, 8'd128, 1'b0, 1'b0, "reset_edge");
    period(1'b0, 256, 0, 8'd128, 256, 8'd128, "post_reset_low");
    period(1'b0, 256, 128, 8'd128, 256, 8'd128, "post_reset_128");
    repeat (2) step(1'b1, 1'b0, 8'd5, 1'b0, 1'b0, "w4_reset");
    period(1'b1, 16, 0, 8'd5, 16, 8'd5, "w4_first_low");
    repeat (3) period(1'b1, 16, 5, 8'd5, 16, 8'd5, "w4_dty5");
    @(posedge clk);
    #2;
    checks++;
    if (q8.size() + q4.size() != 0) begin
      failures++;
      $display("FAIL drain pending got %0d want 0", q8.size() + q4.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
